mux4_arbiter: RTL and testbench
===============================

MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester and of the output path.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-requester request; req[i] belongs to requester i.
REQ-005 last  input  4  per-requester end-of-burst flag, qualified by the current beat of requester i.
REQ-006 d0, d1, d2, d3  input  WIDTH each  requester data.
REQ-007 out_ready  input  1  downstream accepts the beat this cycle.
REQ-008 gnt  output  4  one-hot grant; all zeros when idle.
REQ-009 sel  output  2  registered select of the granted requester, drives the 4:1 datapath.
REQ-010 out_valid  output  1  a beat is offered downstream.
REQ-011 out_data  output  WIDTH  data of the selected requester.

Function
REQ-012 The block SHALL be a two-state FSM, IDLE and BUSY, sharing one 4:1 WIDTH-bit datapath among four requesters with round-robin fairness.
REQ-013 In IDLE, with any req bit set, the block SHALL choose the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), load sel, set the matching gnt bit and enter BUSY on the next edge.
REQ-014 In IDLE, with req == 0, the block SHALL remain in IDLE with gnt = 0 and sel unchanged.
REQ-015 In BUSY: out_valid = req[sel]; out_data = d[sel] (combinational through the mux); gnt stays constant.
REQ-016 A beat SHALL transfer exactly when out_valid && out_ready.
REQ-017 When a beat transfers with last[sel] = 1, the next edge SHALL return to IDLE, clear gnt and set ptr = sel + 1 (mod 4).
REQ-018 When req[sel] = 0 in BUSY (abandoned burst), the next edge SHALL return to IDLE, clear gnt and set ptr = sel + 1 (mod 4).
REQ-019 In BUSY, requests from non-granted requesters SHALL be ignored until the grant is released; no preemption.
REQ-020 Grant latency SHALL be one cycle: req seen in IDLE at edge N gives gnt and out_valid from edge N+1.
REQ-021 Exactly one IDLE cycle SHALL separate consecutive grants, even with requests pending.
REQ-022 out_valid SHALL be 0 whenever the state is IDLE.
REQ-023 ptr wrap-around: sel = 3 released SHALL give ptr = 0.
REQ-024 A single-beat burst (last = 1 on the first beat) SHALL be legal: BUSY lasts exactly as long as out_ready is held low, plus one cycle.

Reset
REQ-025 reset SHALL take priority over all other inputs, including mid-burst, and SHALL force state = IDLE, gnt = 0, sel = 0, ptr = 0 and out_valid = 0 on the next edge.
REQ-026 After reset, requester 0 SHALL have highest priority for the first arbitration.

Structure
REQ-027 State encoding (IDLE/BUSY enum) and the requester count constant (4) SHALL live in a shared package.
REQ-028 The datapath SHALL be one sub-module, mux4, parameterized by WIDTH and built from three parameterized 2:1 mux instances (low pair on sel[0], high pair on sel[0], output on sel[1]).
REQ-029 FSM, ptr and gnt/sel registers SHALL be in mux4_arbiter; out_data SHALL have no register stage.

Verification
REQ-030 Reset, then req = 4'b0101, last = 4'b1111, out_ready = 1, d0 = 8'hA0, d2 = 8'hC2 -> gnt = 0001 with out_data = A0 for 1 beat; IDLE cycle; gnt = 0100 with out_data = C2.
REQ-031 Only requester 3 bursts three beats, with last on beat 3 and out_ready = 1 -> 3 transfers, sel = 3, then ptr = 0; next req = 4'b1001 grants requester 0.
REQ-032 In BUSY on requester 1, hold out_ready = 0 for 4 cycles -> out_valid stays 1, out_data is stable and gnt does not change when req[2] rises.
REQ-033 In BUSY on requester 2, drop req[2] without last -> out_valid = 0 the same cycle; IDLE the next cycle; ptr = 3.
REQ-034 Assert reset mid-burst on requester 1 -> the next edge gives gnt = 0, sel = 0, out_valid = 0; with req = 4'b1111 the next grant goes to requester 0.
REQ-035 All four requesters continuously requesting single-beat bursts -> grant order 0, 1, 2, 3, 0, with one IDLE cycle between grants.

Source files
------------

// File: rtl/mux4_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// Holds the FSM state encoding and the round-robin pick helper.
package mux4_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // First set request bit scanning ptr, ptr+1, ... (mod NUM_REQ).
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux4_arbiter_mux4.sv
// Shared 4:1 datapath built as a tree of three 2:1 muxes.
// Purely combinational; out_data carries no register stage.
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

module mux4
  import mux4_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  mux2 #(.WIDTH(WIDTH)) u_lo  (.a(d0), .b(d1), .s(sel[0]), .y(lo));
  mux2 #(.WIDTH(WIDTH)) u_hi  (.a(d2), .b(d3), .s(sel[0]), .y(hi));
  mux2 #(.WIDTH(WIDTH)) u_out (.a(lo), .b(hi), .s(sel[1]), .y(y));
endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter granting one of four requesters a shared datapath
// for a whole burst; an IDLE cycle always separates consecutive grants.
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic [WIDTH-1:0]   d0,
  input  logic [WIDTH-1:0]   d1,
  input  logic [WIDTH-1:0]   d2,
  input  logic [WIDTH-1:0]   d3,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          sel_d        = rr_pick(req, ptr_q);
          gnt_d[sel_d] = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        out_valid = req[sel_q];
        // Release on a final beat or when the owner abandons the burst.
        if (!req[sel_q] || (out_ready && last[sel_q])) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

  mux4 #(.WIDTH(WIDTH)) u_mux4 (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (sel_q),
    .y   (out_data)
  );

endmodule

// File: tb/tb_mux4_arbiter.sv
// Self-checking bench for mux4_arbiter: directed scenarios plus a random
// run compared against a burst-level round-robin reference model.
module tb_mux4_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [7:0] d_arr [4];
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic [7:0] out_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the bus, and where the next scan starts.
  int m_busy  = 0;
  int m_sel   = 0;
  int m_ptr   = 0;

  mux4_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .d0        (d_arr[0]),
    .d1        (d_arr[1]),
    .d2        (d_arr[2]),
    .d3        (d_arr[3]),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int found;
    if (reset) begin
      m_busy = 0;
      m_sel  = 0;
      m_ptr  = 0;
    end else if (m_busy == 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (found == 0 && req[(m_ptr + k) % 4]) begin
          m_sel  = (m_ptr + k) % 4;
          found  = 1;
          m_busy = 1;
        end
      end
    end else begin
      if (!req[m_sel] || (out_ready && last[m_sel])) begin
        m_busy = 0;
        m_ptr  = (m_sel + 1) % 4;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; last = 4'b0000; out_ready = 1'b1;
    cycle();
    cycle();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_vec++; if (sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", sel); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    reset = 1'b0; req = 4'b0000;
    cycle();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    req = 4'b0101; last = 4'b1111; out_ready = 1'b1;
    d_arr[0] = 8'hA0; d_arr[2] = 8'hC2;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle_valid: got %b want 0", out_valid); end
    cycle();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL basic_gnt0: got %b want 0001", gnt); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hA0) begin n_err++; $display("FAIL basic_data0: got v=%b d=%h want v=1 d=a0", out_valid, out_data); end
    cycle();
    n_vec++; if (gnt !== 4'b0000 || out_valid !== 1'b0) begin n_err++; $display("FAIL basic_gap: got gnt=%b v=%b want 0000/0", gnt, out_valid); end
    cycle();
    n_vec++; if (gnt !== 4'b0100 || sel !== 2'd2) begin n_err++; $display("FAIL basic_gnt2: got gnt=%b sel=%0d want 0100/2", gnt, sel); end
    n_vec++; if (out_data !== 8'hC2) begin n_err++; $display("FAIL basic_data2: got %h want c2", out_data); end
    req = 4'b0000;
    cycle();
    $display("test_basic done");
  endtask

  task automatic test_wrap();
    req = 4'b1000; last = 4'b0000; out_ready = 1'b1; d_arr[3] = 8'h31;
    cycle();
    n_vec++; if (gnt !== 4'b1000 || sel !== 2'd3) begin n_err++; $display("FAIL wrap_gnt3: got gnt=%b sel=%0d want 1000/3", gnt, sel); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h31) begin n_err++; $display("FAIL wrap_beat1: got v=%b d=%h want v=1 d=31", out_valid, out_data); end
    d_arr[3] = 8'h32;
    cycle();
    n_vec++; if (gnt !== 4'b1000 || out_data !== 8'h32) begin n_err++; $display("FAIL wrap_beat2: got gnt=%b d=%h want 1000/32", gnt, out_data); end
    d_arr[3] = 8'h33; last = 4'b1000;
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h33) begin n_err++; $display("FAIL wrap_beat3: got v=%b d=%h want v=1 d=33", out_valid, out_data); end
    cycle();
    n_vec++; if (gnt !== 4'b0000 || out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_release: got gnt=%b v=%b want 0000/0", gnt, out_valid); end
    req = 4'b1001; last = 4'b0001;
    cycle();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_ptr0: got %b want 0001", gnt); end
    cycle();
    req = 4'b0000;
    $display("test_wrap done");
  endtask

  task automatic test_backpressure();
    req = 4'b0010; last = 4'b0010; out_ready = 1'b0; d_arr[1] = 8'h5A;
    cycle();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL bp_gnt1: got %b want 0010", gnt); end
    req = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_vec++; if (gnt !== 4'b0010 || out_valid !== 1'b1 || out_data !== 8'h5A) begin
        n_err++; $display("FAIL bp_hold%0d: got gnt=%b v=%b d=%h want 0010/1/5a", i, gnt, out_valid, out_data);
      end
    end
    out_ready = 1'b1; req = 4'b0010;
    cycle();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL bp_release: got %b want 0000", gnt); end
    req = 4'b0000;
    $display("test_backpressure done");
  endtask

  task automatic test_abandon();
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    cycle();
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL ab_gnt2: got %b want 0100", gnt); end
    req = 4'b0000;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ab_valid: got %b want 0", out_valid); end
    cycle();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL ab_idle: got %b want 0000", gnt); end
    req = 4'b1111;
    cycle();
    n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL ab_ptr3: got %b want 1000", gnt); end
    last = 4'b1111;
    cycle();
    req = 4'b0000;
    $display("test_abandon done");
  endtask

  task automatic test_reset_mid();
    req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
    cycle();
    cycle();
    n_vec++; if (gnt !== 4'b0010 || sel !== 2'd1) begin n_err++; $display("FAIL rm_busy1: got gnt=%b sel=%0d want 0010/1", gnt, sel); end
    reset = 1'b1; req = 4'b1111;
    cycle();
    n_vec++; if (gnt !== 4'b0000 || sel !== 2'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rm_reset: got gnt=%b sel=%0d v=%b want 0000/0/0", gnt, sel, out_valid);
    end
    reset = 1'b0;
    cycle();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rm_prio0: got %b want 0001", gnt); end
    last = 4'b1111;
    cycle();
    req = 4'b0000;
    $display("test_reset_mid done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    reset = 1'b1;
    cycle();
    reset = 1'b0; req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      n_vec++; if (gnt !== exp_seq[i] || out_valid !== (exp_seq[i] != 4'b0000)) begin
        n_err++; $display("FAIL rr_step%0d: got gnt=%b v=%b want %b", i, gnt, out_valid, exp_seq[i]);
      end
    end
    req = 4'b0000;
    cycle();
    $display("test_round_robin done");
  endtask

  task automatic test_random();
    logic [3:0] exp_gnt;
    logic       exp_valid;
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      req       = 4'($urandom);
      last      = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 4; j++) d_arr[j] = 8'($urandom);
      #1;
      exp_gnt   = (m_busy != 0) ? 4'(1 << m_sel) : 4'b0000;
      exp_valid = (m_busy != 0) && req[m_sel];
      n_vec++; if (gnt !== exp_gnt || sel !== 2'(m_sel) || out_valid !== exp_valid) begin
        n_err++; $display("FAIL rand%0d_ctl: got gnt=%b sel=%0d v=%b want %b/%0d/%b", i, gnt, sel, out_valid, exp_gnt, m_sel, exp_valid);
      end
      if (exp_valid) begin
        n_vec++; if (out_data !== d_arr[m_sel]) begin
          n_err++; $display("FAIL rand%0d_data: got %h want %h", i, out_data, d_arr[m_sel]);
        end
      end
      cycle();
    end
    reset = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1; req = 4'b0000; last = 4'b0000; out_ready = 1'b0;
    for (int j = 0; j < 4; j++) d_arr[j] = 8'h00;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_abandon();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
